axis_pattern_gen: RTL

AXI4-Stream source that emits programmable frames of known data, for driving the stream counter / debugger path without external traffic. It sits directly upstream of the debugger's input stream. A bench or software checks the byte and tlast counts reported downstream against the programmed frame length and count. Frames are produced back-to-back at full rate whenever the downstream sink is ready.

---
 rtl/axis_pattern_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - AXI4-Stream programmable frame pattern source
//
// Emits frames of frame_len beats and runs of num_frames frames back-to-back.
// The data is an incrementing word count or, when built with PATGEN_LFSR_EN,
// optionally a 32-bit Galois LFSR sequence.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, stop          run request (sampled in IDLE) / finish-after-frame level
//   frame_len            beats per frame, latched on start (0 acts as 1)
//   num_frames           frames per run, latched on start (0 = until stop)
//   mode                 0 incrementing, 1 LFSR (only with PATGEN_LFSR_EN)
//   busy, done           run status / one-cycle pulse on return to IDLE
//   frames_sent          frames completed in the current/last run
//   output_m_axis_*      registered AXI4-Stream master
//
// Build option: PATGEN_LFSR_EN enables the LFSR and the mode input.
module axis_pattern_gen #(
  parameter int C_AXIS_BYTEWIDTH = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            stop,
  input  logic [31:0]                     frame_len,
  input  logic [15:0]                     num_frames,
  input  logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     frames_sent,
  output logic                            output_m_axis_tvalid,
  output logic [8*C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]     output_m_axis_tstrb,
  output logic                            output_m_axis_tlast,
  input  logic                            output_m_axis_tready
);

  localparam int          DW        = 8 * C_AXIS_BYTEWIDTH;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [15:0]     num_q, num_d;
  logic [31:0]     beat_q, beat_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     frames_q, frames_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [31:0]     len_eff;
  logic            xfer;
  logic            run_end;

  function automatic logic [DW-1:0] inc_data(input logic [31:0] w);
    logic [63:0] t;
    t = {32'd0, w};
    return t[DW-1:0];
  endfunction

`ifdef PATGEN_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic        mode_q, mode_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 32'd0);
  endfunction

  // The 32-bit LFSR value is repeated to fill stream widths above 4 bytes.
  function automatic logic [DW-1:0] pick_data(input logic [31:0] w,
                                              input logic [31:0] l,
                                              input logic        m);
    logic [63:0] t;
    t = {l, l};
    return m ? t[DW-1:0] : inc_data(w);
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign len_eff = (frame_len == 32'd0) ? 32'd1 : frame_len;
  assign xfer    = tvalid_q && output_m_axis_tready;
  // The run ends on a tlast transfer when the count is reached or stop is up.
  assign run_end = ((num_q != 16'd0) && ((frames_q + 32'd1) == {16'd0, num_q})) || stop;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    num_d    = num_q;
    beat_d   = beat_q;
    word_d   = word_q;
    frames_d = frames_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef PATGEN_LFSR_EN
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          len_d    = len_eff;
          num_d    = num_frames;
          beat_d   = 32'd0;
          word_d   = 32'd0;
          frames_d = 32'd0;
          tvalid_d = 1'b1;
          tlast_d  = (len_eff == 32'd1);
          busy_d   = 1'b1;
`ifdef PATGEN_LFSR_EN
          lfsr_d   = LFSR_SEED;
          mode_d   = mode;
          tdata_d  = pick_data(32'd0, LFSR_SEED, mode);
`else
          tdata_d  = inc_data(32'd0);
`endif
        end
      end
      S_RUN: begin
        if (xfer) begin
          word_d = word_q + 32'd1;
`ifdef PATGEN_LFSR_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
          beat_d = tlast_q ? 32'd0 : (beat_q + 32'd1);
          if (tlast_q) begin
            frames_d = frames_q + 32'd1;
          end
          if (tlast_q && run_end) begin
            state_d  = S_FINISH;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            tlast_d  = (beat_d == (len_q - 32'd1));
`ifdef PATGEN_LFSR_EN
            tdata_d  = pick_data(word_d, lfsr_d, mode_q);
`else
            tdata_d  = inc_data(word_d);
`endif
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      len_q    <= 32'd1;
      num_q    <= 16'd0;
      beat_q   <= 32'd0;
      word_q   <= 32'd0;
      frames_q <= 32'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PATGEN_LFSR_EN
      lfsr_q   <= LFSR_SEED;
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      num_q    <= num_d;
      beat_q   <= beat_d;
      word_q   <= word_d;
      frames_q <= frames_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PATGEN_LFSR_EN
      lfsr_q   <= lfsr_d;
      mode_q   <= mode_d;
`endif
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign frames_sent          = frames_q;
  assign output_m_axis_tvalid = tvalid_q;
  assign output_m_axis_tdata  = tdata_q;
  assign output_m_axis_tstrb  = '1;
  assign output_m_axis_tlast  = tlast_q;

endmodule
